host_cmd_fsm: RTL and testbench

//  Upstream command decoder for the control register file. Consumes a byte stream from the host

---
 rtl/host_cmd_pkg.sv | 21 ++
 rtl/host_cmd_timer.sv | 44 ++++
 rtl/host_cmd_fsm.sv | 141 ++++++++++++++
 tb/tb_host_cmd_fsm.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/host_cmd_pkg.sv
// Package: host_cmd_pkg
// Shared definitions for the host command decoder.
//   state_t      : decoder FSM states
//   RW_BIT       : bit of frame byte0 that selects write (1) or read (0)
//   ACK_BYTE_DEF : default response to a successful write
//   NAK_BYTE_DEF : default response to an out-of-range address
package host_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_DATA = 3'd1,
    WRITE    = 3'd2,
    READ     = 3'd3,
    TX       = 3'd4
  } state_t;

  localparam int          RW_BIT       = 7;
  localparam logic [7:0]  ACK_BYTE_DEF = 8'hA5;
  localparam logic [7:0]  NAK_BYTE_DEF = 8'hEE;

endpackage

// File: rtl/host_cmd_timer.sv
// Module: host_cmd_timer
// Clearable up-counter that bounds the gap between frame byte0 and byte1.
// Ports:
//   clk      in  system clock
//   rst      in  asynchronous active-high reset
//   clr_i    in  hold counter at zero (asserted whenever not waiting for byte1)
//   expire_o out high during the cycle the count reaches TIMEOUT_CYC-1
module host_cmd_timer #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The owner leaves the waiting state on expiry, which clears the counter,
  // so it never needs to wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/host_cmd_fsm.sv
// Module: host_cmd_fsm
// Decodes host byte frames into register-file strobes.
//   Write frame: {1'b1, a[6:0]}, data   Read frame: {1'b0, a[6:0]}
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rx_data_i/valid_i/ready_o  byte stream from the serial receiver
//   tx_data_o/valid_o/ready_i  response byte to the serial transmitter
//   addr_o, wr_data_o, wr_en_o register-file write side
//   rd_data_i                register read data (combinational on addr_o)
//   busy_o                   high whenever not IDLE
//   err_o                    1-cycle pulse on timeout or out-of-range address
// Build option: define CMD_ACK_EN to answer in-range writes with ACK_BYTE.
module host_cmd_fsm
  import host_cmd_pkg::*;
#(
  parameter int         NUM_REGS    = 8,
  parameter int         TIMEOUT_CYC = 100000,
  parameter logic [7:0] ACK_BYTE    = ACK_BYTE_DEF,
  parameter logic [7:0] NAK_BYTE    = NAK_BYTE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       rx_ready_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic [7:0] addr_o,
  output logic [7:0] wr_data_o,
  output logic       wr_en_o,
  input  logic [7:0] rd_data_i,
  output logic       busy_o,
  output logic       err_o
);

  state_t     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       in_range;
  logic       expire;

  // Counter only runs while waiting for the data byte.
  host_cmd_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (state_q != GET_DATA),
    .expire_o(expire)
  );

  assign in_range = (32'(addr_q) < NUM_REGS);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    tx_data_d  = tx_data_q;
    rx_ready_o = 1'b0;
    tx_valid_o = 1'b0;
    wr_en_o    = 1'b0;
    err_o      = 1'b0;

    unique case (state_q)
      IDLE: begin
        rx_ready_o = 1'b1;
        if (rx_valid_i) begin
          addr_d  = {1'b0, rx_data_i[6:0]};
          state_d = rx_data_i[RW_BIT] ? GET_DATA : READ;
        end
      end
      GET_DATA: begin
        // Still ready on the expiry cycle: a byte handed over then is
        // consumed and discarded, and the frame is aborted.
        rx_ready_o = 1'b1;
        if (expire) begin
          err_o   = 1'b1;
          state_d = IDLE;
        end else if (rx_valid_i) begin
          wr_data_d = rx_data_i;
          state_d   = WRITE;
        end
      end
      WRITE: begin
        if (in_range) begin
          wr_en_o = 1'b1;
`ifdef CMD_ACK_EN
          tx_data_d = ACK_BYTE;
          state_d   = TX;
`else
          state_d   = IDLE;
`endif
        end else begin
          err_o     = 1'b1;
          tx_data_d = NAK_BYTE;
          state_d   = TX;
        end
      end
      READ: begin
        if (in_range) begin
          tx_data_d = rd_data_i;
        end else begin
          err_o     = 1'b1;
          tx_data_d = NAK_BYTE;
        end
        state_d = TX;
      end
      TX: begin
        tx_valid_o = 1'b1;
        if (tx_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wr_data_q <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign addr_o    = addr_q;
  assign wr_data_o = wr_data_q;
  assign tx_data_o = tx_data_q;
  assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_host_cmd_fsm.sv
// Testbench: tb_host_cmd_fsm
// Directed checks of host_cmd_fsm with TIMEOUT_CYC=16, NUM_REGS=8.
module tb_host_cmd_fsm;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic       rx_ready_o;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i;
  logic [7:0] addr_o;
  logic [7:0] wr_data_o;
  logic       wr_en_o;
  logic [7:0] rd_data_i;
  logic       busy_o;
  logic       err_o;

  int total = 0;
  int bad   = 0;
  int wr_cnt  = 0;
  int err_cnt = 0;

  host_cmd_fsm #(
    .NUM_REGS   (8),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data_i (rx_data_i),
    .rx_valid_i(rx_valid_i),
    .rx_ready_o(rx_ready_o),
    .tx_data_o (tx_data_o),
    .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i),
    .addr_o    (addr_o),
    .wr_data_o (wr_data_o),
    .wr_en_o   (wr_en_o),
    .rd_data_i (rd_data_i),
    .busy_o    (busy_o),
    .err_o     (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters: number of cycles each strobe was high at a clock edge.
  always @(posedge clk) begin
    if (wr_en_o) wr_cnt <= wr_cnt + 1;
    if (err_o)   err_cnt <= err_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
    $display("chk %s got=%0h want=%0h", tag, obs, exp_v);
  endtask

  initial begin
    rst        = 1'b1;
    rx_data_i  = 8'h00;
    rx_valid_i = 1'b0;
    tx_ready_i = 1'b1;
    rd_data_i  = 8'h00;
    tick();
    tick();

    // Reset state
    chk("rst_rx_ready", 32'(rx_ready_o), 32'h1);
    chk("rst_busy",     32'(busy_o),     32'h0);
    chk("rst_tx_valid", 32'(tx_valid_o), 32'h0);
    chk("rst_wr_en",    32'(wr_en_o),    32'h0);
    chk("rst_err",      32'(err_o),      32'h0);
    chk("rst_addr",     32'(addr_o),     32'h0);
    chk("rst_tx_data",  32'(tx_data_o),  32'h0);
    chk("rst_wr_data",  32'(wr_data_o),  32'h0);
    rst = 1'b0;
    tick();

    // 1: write 0x83, 0x5C
    rx_data_i = 8'h83; rx_valid_i = 1'b1;
    chk("t1_rx_ready", 32'(rx_ready_o), 32'h1);
    tick();
    chk("t1_busy",  32'(busy_o),  32'h1);
    chk("t1_addr",  32'(addr_o),  32'h03);
    chk("t1_nowr",  32'(wr_en_o), 32'h0);
    rx_data_i = 8'h5C;
    tick();
    rx_valid_i = 1'b0;
    chk("t1_wr_en",    32'(wr_en_o),    32'h1);
    chk("t1_wr_data",  32'(wr_data_o),  32'h5C);
    chk("t1_addr_w",   32'(addr_o),     32'h03);
    chk("t1_rx_block", 32'(rx_ready_o), 32'h0);
    tick();
`ifdef CMD_ACK_EN
    chk("t1_ack_valid", 32'(tx_valid_o), 32'h1);
    chk("t1_ack_data",  32'(tx_data_o),  32'hA5);
    chk("t1_wr_off",    32'(wr_en_o),    32'h0);
    tick();
`endif
    chk("t1_wr_done", 32'(wr_en_o), 32'h0);
    chk("t1_idle",    32'(busy_o),  32'h0);
    chk("t1_wr_cnt",  32'(wr_cnt),  32'h1);

    // 2: read 0x03 -> tx 0x5C two cycles after accept
    rd_data_i = 8'h5C;
    rx_data_i = 8'h03; rx_valid_i = 1'b1;
    tick();
    rx_valid_i = 1'b0;
    chk("t2_lat1_valid", 32'(tx_valid_o), 32'h0);
    chk("t2_busy",       32'(busy_o),     32'h1);
    tick();
    chk("t2_tx_valid", 32'(tx_valid_o), 32'h1);
    chk("t2_tx_data",  32'(tx_data_o),  32'h5C);
    chk("t2_no_err",   32'(err_o),      32'h0);
    tick();
    chk("t2_tx_done", 32'(tx_valid_o), 32'h0);
    chk("t2_idle",    32'(busy_o),     32'h0);

    // 3: write to address 10 -> NAK
    rx_data_i = 8'h8A; rx_valid_i = 1'b1;
    tick();
    rx_data_i = 8'h11;
    tick();
    rx_valid_i = 1'b0;
    chk("t3_no_wr", 32'(wr_en_o), 32'h0);
    chk("t3_err",   32'(err_o),   32'h1);
    chk("t3_addr",  32'(addr_o),  32'h0A);
    tick();
    chk("t3_tx_valid", 32'(tx_valid_o), 32'h1);
    chk("t3_tx_nak",   32'(tx_data_o),  32'hEE);
    chk("t3_err_off",  32'(err_o),      32'h0);
    tick();
    chk("t3_idle",    32'(busy_o),  32'h0);
    chk("t3_wr_cnt",  32'(wr_cnt),  32'h1);
    chk("t3_err_cnt", 32'(err_cnt), 32'h1);

    // 4: 0x81 then silence -> timeout after 16 cycles in GET_DATA
    rx_data_i = 8'h81; rx_valid_i = 1'b1;
    tick();
    rx_valid_i = 1'b0;
    repeat (14) tick();
    chk("t4_pre_err", 32'(err_o),  32'h0);
    chk("t4_waiting", 32'(busy_o), 32'h1);
    tick();
    chk("t4_err",      32'(err_o),      32'h1);
    chk("t4_rx_ready", 32'(rx_ready_o), 32'h1);
    // byte offered on the timeout cycle must be dropped
    rx_data_i = 8'h77; rx_valid_i = 1'b1;
    tick();
    rx_valid_i = 1'b0;
    chk("t4_idle",     32'(busy_o),    32'h0);
    chk("t4_err_off",  32'(err_o),     32'h0);
    chk("t4_err_cnt",  32'(err_cnt),   32'h2);
    chk("t4_wr_cnt",   32'(wr_cnt),    32'h1);
    chk("t4_wr_data",  32'(wr_data_o), 32'h11);
    rd_data_i = 8'h3C;
    rx_data_i = 8'h01; rx_valid_i = 1'b1;
    tick();
    rx_valid_i = 1'b0;
    tick();
    chk("t4_rd_valid", 32'(tx_valid_o), 32'h1);
    chk("t4_rd_data",  32'(tx_data_o),  32'h3C);
    chk("t4_rd_addr",  32'(addr_o),     32'h01);
    tick();
    chk("t4_rd_idle", 32'(busy_o), 32'h0);

    // 5: transmitter stalls for 20 cycles
    rd_data_i  = 8'h99;
    tx_ready_i = 1'b0;
    rx_data_i = 8'h02; rx_valid_i = 1'b1;
    tick();
    rx_valid_i = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("t5_hold_valid_%0d", i), 32'(tx_valid_o), 32'h1);
      chk($sformatf("t5_hold_data_%0d", i),  32'(tx_data_o),  32'h99);
      chk($sformatf("t5_rx_block_%0d", i),   32'(rx_ready_o), 32'h0);
      tick();
    end
    tx_ready_i = 1'b1;
    chk("t5_still_valid", 32'(tx_valid_o), 32'h1);
    tick();
    chk("t5_released", 32'(tx_valid_o), 32'h0);
    chk("t5_idle",     32'(busy_o),     32'h0);

    // 6a: reset while in GET_DATA
    rx_data_i = 8'h84; rx_valid_i = 1'b1;
    tick();
    rx_data_i = 8'h22;
    chk("t6_in_getdata", 32'(busy_o), 32'h1);
    rst = 1'b1;
    #1;
    chk("t6_rst_idle",  32'(busy_o),     32'h0);
    chk("t6_rst_ready", 32'(rx_ready_o), 32'h1);
    chk("t6_rst_addr",  32'(addr_o),     32'h0);
    rx_valid_i = 1'b0;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("t6_no_write", 32'(wr_cnt),  32'h1);
    chk("t6_wr_low",   32'(wr_en_o), 32'h0);

    // 6b: reset while in TX
    tx_ready_i = 1'b0;
    rx_data_i = 8'h05; rx_valid_i = 1'b1;
    tick();
    rx_valid_i = 1'b0;
    tick();
    chk("t6_in_tx", 32'(tx_valid_o), 32'h1);
    rst = 1'b1;
    #1;
    chk("t6_tx_drop", 32'(tx_valid_o), 32'h0);
    chk("t6_tx_idle", 32'(busy_o),     32'h0);
    tick();
    rst = 1'b0;
    tx_ready_i = 1'b1;
    tick();
    chk("t6_tx_stays_low", 32'(tx_valid_o), 32'h0);
    chk("t6_final_wr_cnt", 32'(wr_cnt),     32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
